// File: rtl/ram_host_arb_pkg.sv
// Shared types and constants for the two-host SRAM arbiter.
package ram_host_arb_pkg;

    localparam int NumHosts = 2;

    typedef logic [0:0] host_idx_t;

    localparam host_idx_t HostInstr = 1'b0;
    localparam host_idx_t HostData  = 1'b1;

    typedef struct packed {
        logic      valid;
        host_idx_t host;
        logic      err;
        logic      ram;
    } rsp_t;

endpackage

// File: rtl/ram_host_arb_chk.sv
// Simulation-only protocol checker: the SRAM must answer exactly the cycles
// after the arbiter issued a request.
module ram_host_arb_chk (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ram_rvalid_i,
    input  logic rsp_ram_i
);

    rvalid_matches_req: assert property (
        @(posedge clk_i) disable iff (rst_i) ram_rvalid_i == rsp_ram_i
    ) else $error("protocol check: ram_rvalid_i differs from issued request");

endmodule

// File: rtl/ram_host_arb_rr.sv
// Two-way round-robin arbiter: a lone requester wins at once, a tie goes to
// the host that was not granted most recently.
module ram_host_arb_rr
    import ram_host_arb_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumHosts-1:0] req_i,
    output logic [NumHosts-1:0] gnt_o,
    output host_idx_t           idx_o
);

    host_idx_t last_gnt_q;
    host_idx_t last_gnt_d;

    // Grant selection and last-winner update.
    always_comb begin
        gnt_o      = 2'b00;
        idx_o      = HostInstr;
        last_gnt_d = last_gnt_q;
        case (req_i)
            2'b01: begin
                gnt_o = 2'b01;
                idx_o = HostInstr;
            end
            2'b10: begin
                gnt_o = 2'b10;
                idx_o = HostData;
            end
            2'b11: begin
                idx_o = ~last_gnt_q;
                gnt_o = (idx_o == HostData) ? 2'b10 : 2'b01;
            end
            default: begin
                gnt_o = 2'b00;
                idx_o = HostInstr;
            end
        endcase
        if (|req_i) begin
            last_gnt_d = idx_o;
        end else begin
            last_gnt_d = last_gnt_q;
        end
    end

    // Last-winner register; resets to the data host so instruction wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt_q <= HostData;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/ram_host_arb.sv
// Merges the instruction and data host ports onto one SRAM port, decodes the
// SRAM window, steers responses back and counts contention cycles.
module ram_host_arb
    import ram_host_arb_pkg::*;
#(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0010_0000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumHosts-1:0]       host_req_i,
    output logic [NumHosts-1:0]       host_gnt_o,
    input  logic [NumHosts-1:0]       host_we_i,
    input  logic [NumHosts-1:0][3:0]  host_be_i,
    input  logic [NumHosts-1:0][31:0] host_addr_i,
    input  logic [NumHosts-1:0][31:0] host_wdata_i,
    output logic [NumHosts-1:0]       host_rvalid_o,
    output logic [31:0]               host_rdata_o,
    output logic [NumHosts-1:0]       host_err_o,
    output logic                      ram_req_o,
    output logic                      ram_we_o,
    output logic [3:0]                ram_be_o,
    output logic [31:0]               ram_addr_o,
    output logic [31:0]               ram_wdata_o,
    input  logic                      ram_rvalid_i,
    input  logic [31:0]               ram_rdata_i,
    output logic [15:0]               contention_cnt_o
);

    localparam logic [32:0] WinLo = {1'b0, BaseAddr};
    localparam logic [32:0] WinHi = WinLo + (33'(Depth) << 2);

    host_idx_t   gnt_idx_s;
    logic [32:0] sel_addr_s;
    logic        any_gnt_s;
    logic        in_range_s;
    logic        wr_viol_s;
    rsp_t        rsp_q;
    rsp_t        rsp_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    ram_host_arb_rr u_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (host_req_i),
        .gnt_o (host_gnt_o),
        .idx_o (gnt_idx_s)
    );

    // Window decode of the winning host and SRAM port drive.
    always_comb begin
        sel_addr_s  = {1'b0, host_addr_i[gnt_idx_s]};
        any_gnt_s   = |host_gnt_o;
        in_range_s  = (sel_addr_s >= WinLo) && (sel_addr_s < WinHi);
        wr_viol_s   = (gnt_idx_s == HostInstr) && host_we_i[gnt_idx_s];
        ram_req_o   = any_gnt_s && in_range_s;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = 32'h0;
        ram_wdata_o = 32'h0;
        if (ram_req_o) begin
            ram_we_o    = host_we_i[gnt_idx_s] && !wr_viol_s;
            ram_be_o    = host_be_i[gnt_idx_s];
            ram_addr_o  = host_addr_i[gnt_idx_s] - BaseAddr;
            ram_wdata_o = host_wdata_i[gnt_idx_s];
        end else begin
            ram_we_o    = 1'b0;
            ram_be_o    = 4'h0;
            ram_addr_o  = 32'h0;
            ram_wdata_o = 32'h0;
        end
        rsp_d.valid = any_gnt_s;
        rsp_d.host  = gnt_idx_s;
        rsp_d.err   = any_gnt_s && (!in_range_s || wr_viol_s);
        rsp_d.ram   = ram_req_o;
    end

    // Response tracking for the access granted last cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_q <= '{valid: 1'b0, host: HostInstr, err: 1'b0, ram: 1'b0};
        end else begin
            rsp_q <= rsp_d;
        end
    end

    // Response steering; errored or SRAM-less accesses return zero data.
    always_comb begin
        host_rvalid_o              = {NumHosts{1'b0}};
        host_err_o                 = {NumHosts{1'b0}};
        host_rvalid_o[rsp_q.host]  = rsp_q.valid;
        host_err_o[rsp_q.host]     = rsp_q.err && rsp_q.valid;
        if (rsp_q.ram && !rsp_q.err) begin
            host_rdata_o = ram_rdata_i;
        end else begin
            host_rdata_o = 32'h0;
        end
    end

    // Saturating contention counter next state.
    always_comb begin
        if ((&host_req_i) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Contention counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 16'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign contention_cnt_o = cnt_q;

    ram_host_arb_chk u_chk (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ram_rvalid_i (ram_rvalid_i),
        .rsp_ram_i    (rsp_q.ram)
    );

endmodule

// File: tb/tb_ram_host_arb.sv
// Directed plus randomized bench for ram_host_arb with a behavioural SRAM
// and a reference model of arbitration, window decode and responses.
module tb_ram_host_arb;

    localparam int          Depth = 128;
    localparam logic [31:0] Base  = 32'h0010_0000;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [1:0]       host_req_i = 2'b00;
    logic [1:0]       host_gnt_o;
    logic [1:0]       host_we_i = 2'b00;
    logic [1:0][3:0]  host_be_i = '0;
    logic [1:0][31:0] host_addr_i = '0;
    logic [1:0][31:0] host_wdata_i = '0;
    logic [1:0]       host_rvalid_o;
    logic [31:0]      host_rdata_o;
    logic [1:0]       host_err_o;
    logic             ram_req_o;
    logic             ram_we_o;
    logic [3:0]       ram_be_o;
    logic [31:0]      ram_addr_o;
    logic [31:0]      ram_wdata_o;
    logic             ram_rvalid_i;
    logic [31:0]      ram_rdata_i;
    logic [15:0]      contention_cnt_o;

    logic [31:0] sram_mem [Depth];
    logic [31:0] mdl_mem  [Depth];
    int          last_gnt;
    int          cnt_m;
    logic [1:0]  e_rv;
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    int          total  = 0;
    int          passed = 0;
    int          fails  = 0;

    ram_host_arb #(.Depth(Depth), .BaseAddr(Base)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .host_req_i       (host_req_i),
        .host_gnt_o       (host_gnt_o),
        .host_we_i        (host_we_i),
        .host_be_i        (host_be_i),
        .host_addr_i      (host_addr_i),
        .host_wdata_i     (host_wdata_i),
        .host_rvalid_o    (host_rvalid_o),
        .host_rdata_o     (host_rdata_o),
        .host_err_o       (host_err_o),
        .ram_req_o        (ram_req_o),
        .ram_we_o         (ram_we_o),
        .ram_be_o         (ram_be_o),
        .ram_addr_o       (ram_addr_o),
        .ram_wdata_o      (ram_wdata_o),
        .ram_rvalid_i     (ram_rvalid_i),
        .ram_rdata_i      (ram_rdata_i),
        .contention_cnt_o (contention_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural SRAM: contents initialised on reset, one-cycle read latency.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) sram_mem[i] <= 32'hC0DE_0000 + 32'(i);
            ram_rvalid_i <= 1'b0;
            ram_rdata_i  <= 32'h0;
        end else begin
            ram_rvalid_i <= ram_req_o;
            if (ram_req_o && ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) sram_mem[ram_addr_o[8:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
                ram_rdata_i <= 32'h0;
            end else if (ram_req_o) begin
                ram_rdata_i <= sram_mem[ram_addr_o[8:2]];
            end else begin
                ram_rdata_i <= 32'hA5A5_A5A5;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (fail #%0d)", tag, obs, exp, fails);
        end
    endtask

    task automatic model_reset();
        last_gnt = 1;
        cnt_m    = 0;
        e_rv     = 2'b00;
        e_err    = 2'b00;
        e_rd     = 32'h0;
        for (int i = 0; i < Depth; i++) mdl_mem[i] = 32'hC0DE_0000 + 32'(i);
    endtask

    task automatic set_host(input int h, input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        host_req_i[h]   = req;
        host_we_i[h]    = we;
        host_be_i[h]    = be;
        host_addr_i[h]  = addr;
        host_wdata_i[h] = wdata;
    endtask

    // One clock: check the response owed from last cycle, predict and check
    // this cycle's grant and SRAM drive, then advance the model.
    task automatic cycle();
        int          w;
        logic        inr;
        logic        viol;
        logic        wr;
        logic [31:0] off;
        #1;
        chk("rvalid", 32'(host_rvalid_o), 32'(e_rv));
        chk("err", 32'(host_err_o), 32'(e_err));
        chk("rdata", host_rdata_o, e_rd);
        chk("cnt", 32'(contention_cnt_o), 32'(cnt_m));
        w = -1;
        if (host_req_i == 2'b11) w = 1 - last_gnt;
        else if (host_req_i[0]) w = 0;
        else if (host_req_i[1]) w = 1;
        if (w < 0) begin
            chk("gnt", 32'(host_gnt_o), 32'h0);
            chk("ram_req", 32'(ram_req_o), 32'h0);
            chk("ram_we", 32'(ram_we_o), 32'h0);
            chk("ram_be", 32'(ram_be_o), 32'h0);
            chk("ram_addr", ram_addr_o, 32'h0);
            chk("ram_wdata", ram_wdata_o, 32'h0);
            e_rv  = 2'b00;
            e_err = 2'b00;
            e_rd  = 32'h0;
        end else begin
            inr  = (longint'(host_addr_i[w]) >= longint'(Base)) &&
                   (longint'(host_addr_i[w]) <  longint'(Base) + longint'(Depth * 4));
            viol = (w == 0) && host_we_i[0];
            wr   = inr && host_we_i[w] && !viol;
            off  = host_addr_i[w] - Base;
            chk("gnt", 32'(host_gnt_o), 32'h1 << w);
            chk("ram_req", 32'(ram_req_o), 32'(inr));
            chk("ram_we", 32'(ram_we_o), 32'(wr));
            chk("ram_be", 32'(ram_be_o), inr ? 32'(host_be_i[w]) : 32'h0);
            chk("ram_addr", ram_addr_o, inr ? off : 32'h0);
            chk("ram_wdata", ram_wdata_o, inr ? host_wdata_i[w] : 32'h0);
            e_rv  = (w == 0) ? 2'b01 : 2'b10;
            e_err = (!inr || viol) ? e_rv : 2'b00;
            e_rd  = (inr && !host_we_i[w]) ? mdl_mem[off[8:2]] : 32'h0;
            if (wr)
                for (int b = 0; b < 4; b++)
                    if (host_be_i[w][b]) mdl_mem[off[8:2]][b*8 +: 8] = host_wdata_i[w][b*8 +: 8];
            last_gnt = w;
        end
        if ((host_req_i == 2'b11) && (cnt_m < 65535)) cnt_m++;
        @(negedge clk_i);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(host_gnt_o), 32'h0);
        chk({tag, "_ram_req"}, 32'(ram_req_o), 32'h0);
        chk({tag, "_ram_addr"}, ram_addr_o, 32'h0);
        chk({tag, "_rvalid"}, 32'(host_rvalid_o), 32'h0);
        chk({tag, "_err"}, 32'(host_err_o), 32'h0);
        chk({tag, "_rdata"}, host_rdata_o, 32'h0);
        chk({tag, "_cnt"}, 32'(contention_cnt_o), 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return Base - 32'd4;
            1:       return Base + 32'(Depth * 4);
            2:       return 32'hFFFF_FFFC;
            default: return Base + ($urandom_range(0, Depth - 1) << 2);
        endcase
    endfunction

    initial begin
        model_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1 check_idle_outputs("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        // Host 1 write then read-back at Base+8.
        set_host(1, 1'b1, 1'b1, 4'hF, Base + 32'd8, 32'hDEAD_BEEF);
        cycle();
        set_host(1, 1'b1, 1'b0, 4'hF, Base + 32'd8, 32'h0);
        cycle();
        #1;
        chk("t1_rdata", host_rdata_o, 32'hDEAD_BEEF);
        chk("t1_rvalid", 32'(host_rvalid_o), 32'h2);
        chk("t1_err", 32'(host_err_o), 32'h0);

        // Six contended cycles: strict alternation starting with host 0.
        set_host(0, 1'b1, 1'b0, 4'hF, Base + 32'd4, 32'h0);
        set_host(1, 1'b1, 1'b0, 4'hF, Base + 32'd12, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1 chk("t2_alt_gnt", 32'(host_gnt_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            cycle();
        end
        host_req_i = 2'b00;
        #1 chk("t2_cnt6", 32'(contention_cnt_o), 32'd6);
        cycle();

        // Host 1 just past the window.
        set_host(1, 1'b1, 1'b0, 4'hF, Base + 32'(Depth * 4), 32'h0);
        #1 chk("t3_gnt", 32'(host_gnt_o), 32'h2);
        chk("t3_ram_req", 32'(ram_req_o), 32'h0);
        cycle();
        host_req_i = 2'b00;
        #1;
        chk("t3_err", 32'(host_err_o), 32'h2);
        chk("t3_rdata", host_rdata_o, 32'h0);
        cycle();

        // Host 0 write attempt must not reach the SRAM.
        set_host(0, 1'b1, 1'b1, 4'hF, Base, 32'h1234_5678);
        cycle();
        host_req_i[0] = 1'b0;
        set_host(1, 1'b1, 1'b0, 4'hF, Base, 32'h0);
        cycle();
        host_req_i = 2'b00;
        #1 chk("t4_unchanged", host_rdata_o, 32'hC0DE_0000);
        cycle();

        // Reset in the response cycle of a contended grant.
        set_host(0, 1'b1, 1'b0, 4'hF, Base + 32'd16, 32'h0);
        set_host(1, 1'b1, 1'b0, 4'hF, Base + 32'd20, 32'h0);
        cycle();
        host_req_i = 2'b00;
        rst_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1 check_idle_outputs("t5_after_rst");
        @(negedge clk_i);
        cycle();

        // Counter saturation from FFF0.
        force dut.cnt_q = 16'hFFF0;
        #1 release dut.cnt_q;
        cnt_m = 32'hFFF0;
        set_host(0, 1'b1, 1'b0, 4'hF, Base, 32'h0);
        set_host(1, 1'b1, 1'b0, 4'hF, Base + 32'd4, 32'h0);
        for (int i = 0; i < 40; i++) cycle();
        host_req_i = 2'b00;
        #1 chk("t6_sat", 32'(contention_cnt_o), 32'h0000_FFFF);
        cycle();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            set_host(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                     4'($urandom_range(1, 15)), rand_addr(), $urandom);
            set_host(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(1, 15)), rand_addr(), $urandom);
            cycle();
        end
        host_req_i = 2'b00;
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_host_arb.md
# ram_host_arb

Two-host arbiter placed directly upstream of the single-port 32-bit SRAM. It merges the Ibex instruction-fetch and data ports onto the SRAM's single req/we/be/addr/wdata port and routes the one-cycle-delayed read data back to the host that issued the access. It also decodes the SRAM address window, answers out-of-window accesses with an error response, and counts contention cycles.

## Interface

Parameters:
- Depth, 128: SRAM depth in 32-bit words; must match the downstream SRAM.
- BaseAddr, 32'h0010_0000: byte base address of the SRAM window; 4-byte aligned.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- host_req_i  in  2  per-host request; index 0 = instruction, 1 = data
- host_gnt_o  out  2  per-host grant, combinational
- host_we_i  in  2  per-host write enable; host 0 is treated as read-only
- host_be_i  in  2x4  per-host byte enables
- host_addr_i  in  2x32  per-host byte address
- host_wdata_i  in  2x32  per-host write data
- host_rvalid_o  out  2  per-host response valid
- host_rdata_o  out  32  response data, shared by both hosts
- host_err_o  out  2  per-host error, qualified by host_rvalid_o
- ram_req_o  out  1  SRAM request
- ram_we_o  out  1  SRAM write enable
- ram_be_o  out  4  SRAM byte enables
- ram_addr_o  out  32  SRAM byte address, offset from BaseAddr
- ram_wdata_o  out  32  SRAM write data
- ram_rvalid_i  in  1  SRAM response valid
- ram_rdata_i  in  32  SRAM read data
- contention_cnt_o  out  16  count of cycles in which both hosts requested; saturating

## Operation

- Arbitration:
  - Only one host requests: that host is granted in the same cycle.
  - Both hosts request: round-robin. The host not granted most recently wins.
  - `last_gnt` is set to 1 at reset, so host 0 wins the first tie.
  - At most one host_gnt_o bit is high in any cycle.
- Address window: an access is in range when BaseAddr <= addr < BaseAddr + Depth*4, using unsigned 33-bit compare.
- In-range grant:
  - ram_req_o = 1.
  - ram_addr_o = addr - BaseAddr.
  - ram_we_o, ram_be_o and ram_wdata_o come from the winning host.
- Host 0 write attempt (we=1): ram_we_o is forced to 0 and the response carries err=1. The read still goes to the SRAM.
- Out-of-range grant:
  - ram_req_o = 0.
  - The grant is still given.
  - The response has err=1 and rdata = 0.
- No grant: ram_req_o = 0. ram_we_o, ram_be_o, ram_addr_o and ram_wdata_o are driven to 0.
- Response tracking registers, loaded every cycle from that cycle's grant:
  - `rsp_valid`: a host was granted.
  - `rsp_host`: index of the granted host.
  - `rsp_err`: error flag for that access.
  - `rsp_ram`: ram_req_o was issued.
- Response outputs:
  - host_rvalid_o[rsp_host] = rsp_valid.
  - host_err_o[rsp_host] = rsp_err & rsp_valid.
  - host_rdata_o = ram_rdata_i when rsp_ram & !rsp_err, else 0.
- Contention counter: increments when both host_req_i bits are 1. It holds at 16'hFFFF.
- Protocol check: simulation-only assertion that ram_rvalid_i == rsp_ram in every cycle. The RTL never uses ram_rvalid_i functionally.

## Timing

- Grant latency is 0 cycles; response latency is exactly 1 cycle after the grant. One new access can be accepted every cycle, so throughput is 1 access per cycle.
- A host may change its request freely while it is not granted.
- Reset values:
  - host_rvalid_o = 0, host_err_o = 0, host_rdata_o = 0.
  - contention_cnt_o = 0.
  - rsp_* registers cleared; last_gnt = 1.
- With req low during reset, every combinational output is 0.
- Reset asserted mid-access: the pending response is dropped. No rvalid appears after reset deasserts, even if the SRAM returns one.
- Back-to-back grants to alternating hosts: each host sees its rvalid in the cycle after its own grant. The rvalids never collide.
- Counter saturation and increment in the same cycle: the value stays at FFFF.

## Structure

- Package ram_host_arb_pkg:
  - localparam NumHosts = 2.
  - typedef host_idx_t (logic [0:0]).
  - localparams HostInstr = 0 and HostData = 1.
  - struct rsp_t {valid, host, err, ram}.
- Sub-module ram_host_arb_rr: the 2-way round-robin arbiter holding last_gnt. It has inputs req[1:0] and outputs gnt[1:0] and idx.
- The window decode and response register stay in the top level.

## Test plan

- Host 1 only writes 32'hDEADBEEF with be=4'hF to BaseAddr+8, then reads the same address -> both grants are immediate, ram_addr_o = 8, and the read returns DEADBEEF with rvalid one cycle later and err=0.
- Both hosts request continuously for 6 cycles -> grants go 0,1,0,1,0,1 and contention_cnt_o = 6.
- Host 1 reads BaseAddr + Depth*4 (just past the window) -> grant given, ram_req_o = 0, next cycle rvalid=1, err=1, rdata=0.
- Host 0 issues a write to BaseAddr -> ram_we_o = 0, response err=1, and SRAM contents are unchanged.
- Reset asserted in the cycle after a grant -> no host_rvalid_o pulse after reset releases, and contention_cnt_o = 0.
- Force the counter to FFF0, then run 40 contended cycles -> the counter sticks at FFFF.
